// File: rtl/cordic_sincos.sv
// Rotation-mode CORDIC: Q16.16-degree angle in, Q16.16 (cos, sin) out.
// The angle is folded into +/-90 deg, then rotated ITER times with the gain pre-applied to x.
module cordic_sincos #(
   parameter int unsigned ITER = 16
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic signed [31:0] theta,
   output logic               out_valid,
   input  logic               out_ready,
   output logic signed [31:0] cos_out,
   output logic signed [31:0] sin_out,
   output logic               out_err
);

   localparam int unsigned W  = 32;
   localparam int unsigned IW = 5;

   localparam logic signed [W-1:0] DEG90  = 32'sd5898240;
   localparam logic signed [W-1:0] DEG180 = 32'sd11796480;
   localparam logic signed [W-1:0] K_GAIN = 32'sd39797;

   typedef enum logic [1:0] {
      S_IDLE,
      S_PRE,
      S_ITER,
      S_DONE
   } state_t;

   state_t              state;
   logic signed [W-1:0] theta_r;
   logic signed [W-1:0] x;
   logic signed [W-1:0] y;
   logic signed [W-1:0] z;
   logic [IW-1:0]       i;
   logic                neg;
   logic                err;

   logic signed [W-1:0] x_sh;
   logic signed [W-1:0] y_sh;
   logic signed [W-1:0] atan_i;
   logic signed [W-1:0] x_nxt;
   logic signed [W-1:0] y_nxt;
   logic signed [W-1:0] z_nxt;

   // round(atan(2^-idx) in degrees x 65536)
   function automatic logic signed [W-1:0] atan_lut(input logic [IW-1:0] idx);
      case (idx)
         5'd0:    atan_lut = 32'sd2949120;
         5'd1:    atan_lut = 32'sd1740967;
         5'd2:    atan_lut = 32'sd919879;
         5'd3:    atan_lut = 32'sd466945;
         5'd4:    atan_lut = 32'sd234379;
         5'd5:    atan_lut = 32'sd117304;
         5'd6:    atan_lut = 32'sd58666;
         5'd7:    atan_lut = 32'sd29335;
         5'd8:    atan_lut = 32'sd14668;
         5'd9:    atan_lut = 32'sd7334;
         5'd10:   atan_lut = 32'sd3667;
         5'd11:   atan_lut = 32'sd1833;
         5'd12:   atan_lut = 32'sd917;
         5'd13:   atan_lut = 32'sd458;
         5'd14:   atan_lut = 32'sd229;
         5'd15:   atan_lut = 32'sd115;
         default: atan_lut = '0;
      endcase
   endfunction

   // One micro-rotation; direction follows the sign of the residual angle.
   always_comb begin
      x_sh   = x >>> i;
      y_sh   = y >>> i;
      atan_i = atan_lut(i);
      x_nxt  = x;
      y_nxt  = y;
      z_nxt  = z;
      if (!z[W-1]) begin
         x_nxt = x - y_sh;
         y_nxt = y + x_sh;
         z_nxt = z - atan_i;
      end else begin
         x_nxt = x + y_sh;
         y_nxt = y - x_sh;
         z_nxt = z + atan_i;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= S_IDLE;
         in_ready  <= 1'b1;
         out_valid <= 1'b0;
         cos_out   <= '0;
         sin_out   <= '0;
         out_err   <= 1'b0;
         theta_r   <= '0;
         x         <= '0;
         y         <= '0;
         z         <= '0;
         i         <= '0;
         neg       <= 1'b0;
         err       <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               if (in_valid && in_ready) begin
                  theta_r  <= theta;
                  in_ready <= 1'b0;
                  state    <= S_PRE;
               end
            end
            // Range check and fold into [-90, +90]; exactly +/-90 stays unfolded.
            S_PRE: begin
               err <= (theta_r > DEG180) || (theta_r < -DEG180);
               if (theta_r > DEG90) begin
                  z   <= theta_r - DEG180;
                  neg <= 1'b1;
               end else if (theta_r < -DEG90) begin
                  z   <= theta_r + DEG180;
                  neg <= 1'b1;
               end else begin
                  z   <= theta_r;
                  neg <= 1'b0;
               end
               x     <= K_GAIN;
               y     <= '0;
               i     <= '0;
               state <= S_ITER;
            end
            S_ITER: begin
               x <= x_nxt;
               y <= y_nxt;
               z <= z_nxt;
               i <= i + IW'(1);
               if (i == IW'(ITER - 1)) begin
                  state     <= S_DONE;
                  out_valid <= 1'b1;
                  out_err   <= err;
                  cos_out   <= err ? '0 : (neg ? -x_nxt : x_nxt);
                  sin_out   <= err ? '0 : (neg ? -y_nxt : y_nxt);
               end
            end
            S_DONE: begin
               if (out_ready) begin
                  state     <= S_IDLE;
                  out_valid <= 1'b0;
                  in_ready  <= 1'b1;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_cordic_sincos.sv
// Bench for cordic_sincos: directed vectors, handshake/reset sequences and random angles vs a real-math model.
module tb_cordic_sincos;

   localparam int unsigned ITER = 16;
   localparam int LAT = ITER + 1;
   localparam int TOL = 24;
   localparam int DEG = 65536;

   logic               clk = 1'b0;
   logic               rst;
   logic               in_valid;
   logic               in_ready;
   logic signed [31:0] theta;
   logic               out_valid;
   logic               out_ready;
   logic signed [31:0] cos_out;
   logic signed [31:0] sin_out;
   logic               out_err;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   cordic_sincos #(.ITER(ITER)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .theta     (theta),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .cos_out   (cos_out),
      .sin_out   (sin_out),
      .out_err   (out_err)
   );

   typedef struct {
      string name;
      int    th;
      int    c;
      int    s;
      bit    e;
   } vec_t;

   vec_t vec[12];

   task automatic check(input string name, input longint act, input longint exp, input longint tol);
      checks++;
      if (act < exp - tol || act > exp + tol) begin
         failures++;
         $display("FAIL %s actual=%0d required=%0d tol=%0d", name, act, exp, tol);
      end
   endtask

   // Ideal result from plain trigonometry.
   task automatic model(input int th, output int c, output int s, output bit e);
      real r;
      e = (th > 180 * DEG) || (th < -180 * DEG);
      if (e) begin
         c = 0;
         s = 0;
      end else begin
         r = real'(th) * 3.14159265358979 / (180.0 * 65536.0);
         c = $rtoi($floor(65536.0 * $cos(r) + 0.5));
         s = $rtoi($floor(65536.0 * $sin(r) + 0.5));
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Transfer one angle and wait (bounded) for the result; result is left pending.
   task automatic start_and_wait(input string name, input int th, output int c, output int s, output bit e);
      int k;
      k = 0;
      while (!in_ready && k < 50) begin
         tick();
         k++;
      end
      check({name, "_in_ready"}, longint'(in_ready), 1, 0);
      in_valid = 1'b1;
      theta    = th;
      tick();
      in_valid = 1'b0;
      theta    = $urandom;
      k = 0;
      while (!out_valid && k < 100) begin
         tick();
         k++;
      end
      check({name, "_latency"}, k, LAT, 0);
      c = cos_out;
      s = sin_out;
      e = out_err;
   endtask

   task automatic deliver(input string name);
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      check({name, "_ready_after"}, longint'(in_ready), 1, 0);
      check({name, "_valid_after"}, longint'(out_valid), 0, 0);
   endtask

   task automatic check_res(input string name, input int c, input int s, input bit e,
                            input int ec, input int es, input bit ee);
      int t;
      t = ee ? 0 : TOL;
      check({name, "_err"}, longint'(e), longint'(ee), 0);
      check({name, "_cos"}, c, ec, t);
      check({name, "_sin"}, s, es, t);
   endtask

   initial begin
      int c, s, mc, ms, th, hc, hs;
      bit e, me, he;

      vec[0]  = '{"zero",      0,              65536,  0,      1'b0};
      vec[1]  = '{"p30",       30 * DEG,       56756,  32768,  1'b0};
      vec[2]  = '{"p45",       45 * DEG,       46341,  46341,  1'b0};
      vec[3]  = '{"p90",       90 * DEG,       0,      65536,  1'b0};
      vec[4]  = '{"m90",       -90 * DEG,      0,      -65536, 1'b0};
      vec[5]  = '{"p180",      180 * DEG,      -65536, 0,      1'b0};
      vec[6]  = '{"m180",      -180 * DEG,     -65536, 0,      1'b0};
      vec[7]  = '{"m135",      -135 * DEG,     -46341, -46341, 1'b0};
      vec[8]  = '{"p120",      120 * DEG,      -32768, 56756,  1'b0};
      vec[9]  = '{"p200",      200 * DEG,      0,      0,      1'b1};
      vec[10] = '{"p180_plus", 180 * DEG + 1,  0,      0,      1'b1};
      vec[11] = '{"m180_minus",-180 * DEG - 1, 0,      0,      1'b1};

      rst       = 1'b1;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      theta     = '0;
      repeat (3) tick();
      check("rst_in_ready",  longint'(in_ready),  1, 0);
      check("rst_out_valid", longint'(out_valid), 0, 0);
      check("rst_cos",       cos_out, 0, 0);
      check("rst_sin",       sin_out, 0, 0);
      check("rst_err",       longint'(out_err), 0, 0);
      rst = 1'b0;
      tick();

      for (int n = 0; n < 12; n++) begin
         start_and_wait(vec[n].name, vec[n].th, c, s, e);
         check_res(vec[n].name, c, s, e, vec[n].c, vec[n].s, vec[n].e);
         deliver(vec[n].name);
      end

      // Back-pressure: hold result 5 cycles while a stray input is offered.
      start_and_wait("hold", 60 * DEG, hc, hs, he);
      check_res("hold", hc, hs, he, 32768, 56756, 1'b0);
      for (int k = 0; k < 5; k++) begin
         in_valid = (k == 2);
         theta    = 10 * DEG;
         tick();
         check("hold_valid",  longint'(out_valid), 1, 0);
         check("hold_ready",  longint'(in_ready),  0, 0);
         check("hold_cos",    cos_out, hc, 0);
         check("hold_sin",    sin_out, hs, 0);
         check("hold_errst",  longint'(out_err), longint'(he), 0);
      end
      in_valid  = 1'b1;
      out_ready = 1'b1;
      tick();
      in_valid  = 1'b0;
      out_ready = 1'b0;
      check("xfer_ready_after", longint'(in_ready),  1, 0);
      check("xfer_valid_after", longint'(out_valid), 0, 0);
      repeat (25) tick();
      check("stray_not_taken_ready", longint'(in_ready),  1, 0);
      check("stray_not_taken_valid", longint'(out_valid), 0, 0);

      // Reset partway through the iterations aborts the operation.
      in_valid = 1'b1;
      theta    = 10 * DEG;
      tick();
      in_valid = 1'b0;
      repeat (9) tick();
      check("abort_busy", longint'(in_ready), 0, 0);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("abort_in_ready",  longint'(in_ready),  1, 0);
      check("abort_out_valid", longint'(out_valid), 0, 0);
      check("abort_cos",       cos_out, 0, 0);
      repeat (20) tick();
      check("abort_no_result", longint'(out_valid), 0, 0);
      start_and_wait("after_abort", 45 * DEG, c, s, e);
      check_res("after_abort", c, s, e, 46341, 46341, 1'b0);
      deliver("after_abort");

      // Random angles across and beyond the legal range.
      for (int n = 0; n < 40; n++) begin
         th = int'($urandom_range(0, 26214400)) - 13107200;
         if (n == 0) th = 90 * DEG + 1;
         if (n == 1) th = -90 * DEG - 1;
         start_and_wait("rand", th, c, s, e);
         model(th, mc, ms, me);
         check_res("rand", c, s, e, mc, ms, me);
         deliver("rand");
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout actual=running required=done");
      $fatal(1, "timeout");
   end

endmodule
